goomba_gravity_mover: RTL and testbench
=======================================

# goomba_gravity_mover

Vertical-motion stage for the Goomba enemy. It produces `goomba_y` for the horizontal Goomba mover, which uses it for its block-collision probes and its Mario stomp/lose checks. The block applies gravity with a saturating fall speed, lands on solid tiles of the 12×17 background grid, and flags a Goomba that falls off the bottom of the screen. It reads back the horizontal mover's `goomba_x` to choose which tile columns support the Goomba.

## Interface
- `BDR`, 0, border tile code (not solid)
- `SKY`, 1, sky tile code (not solid)
- `BLK`, 2, block tile code (solid)
- `GND`, 3, ground tile code (solid)
- `CHARACTER_WIDTH`, 42, Goomba sprite size in pixels (square)
- `SCREEN_WIDTH`, 640, pixels
- `SCREEN_HEIGHT`, 480, pixels
- `BLOCK_WIDTH`, 40, tile size in pixels
- `START_Y`, 398, reset Y position (resting on row-11 ground)
- `MAX_FALL_SPEED`, 4, fall speed ceiling in pixels/cycle; must be < `BLOCK_WIDTH`
- `GRAVITY_PERIOD`, 8, cycles per +1 fall-speed increment

Ports:
- `movement_clock`  in  1  movement tick clock
- `reset`  in  1  asynchronous, active-low
- `background`  in  byte [11:0][16:0]  tile grid, indexed [row][col]
- `goomba_x`  in  int  left edge of the Goomba, from the horizontal mover
- `goomba_y`  out  int  top edge of the Goomba, registered
- `falling`  out  1  high while in FALLING
- `fell`  out  1  high once the Goomba has left the bottom of the screen; sticky until reset

## Operation
Definitions:
- Solid tile: code is `BLK` or `GND`.
- `solid(r,c)`: the tile at row `r`, column `c` is solid. It is false for `r` ≥ 12.
- Columns: `colL = goomba_x / BLOCK_WIDTH` and `colR = (goomba_x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH`. Each is clamped to 16.
- Support row: `rs = (goomba_y + CHARACTER_WIDTH) / BLOCK_WIDTH`.
- Supported: `solid(rs,colL)` or `solid(rs,colR)`.
- Parked: `goomba_x ≥ SCREEN_WIDTH`. This happens when the Goomba was killed and moved off screen.

States:
- **RESET** (entered by async reset). On the next edge, go to GROUNDED if supported, else go to FALLING with `vel` = 1.
- **GROUNDED**
  - If parked, hold.
  - Else if not supported, go to FALLING with `vel` = 1 and `gcnt` = 0.
  - Otherwise `goomba_y` is held.
- **FALLING**
  - If parked, hold all registers.
  - Otherwise compute `cand = goomba_y + vel` and `rl = (cand + CHARACTER_WIDTH) / BLOCK_WIDTH`.
  - If `solid(rl,colL)` or `solid(rl,colR)`: set `goomba_y` ← `rl*BLOCK_WIDTH - CHARACTER_WIDTH`, `vel` ← 0, and go to GROUNDED. The snap is always downward because `vel` < `BLOCK_WIDTH`.
  - Else if `cand ≥ SCREEN_HEIGHT`: set `goomba_y` ← `cand` and go to GONE.
  - Else: set `goomba_y` ← `cand`. Increment `gcnt`. When `gcnt` reaches `GRAVITY_PERIOD - 1`, reset it to 0 and increment `vel`, saturating at `MAX_FALL_SPEED`.
- **GONE**: terminal until reset; `goomba_y` is held.

Arithmetic:
- Signed 32-bit `int` throughout.
- `vel` is 3 bits for the default parameters; size it as `$clog2(MAX_FALL_SPEED+1)`.
- `gcnt` is sized `$clog2(GRAVITY_PERIOD)`.

## Timing
- Reset values (asynchronous): `goomba_y` = `START_Y`, `falling` = 0, `fell` = 0, `vel` = 0, `gcnt` = 0.
- All outputs are registered and change only on `posedge movement_clock`. `falling` and `fell` are decoded from the registered state.
- Tile changes under the Goomba take effect one edge later:
  - Support lost at edge N: state is FALLING and `falling` = 1 after edge N, and `goomba_y` first moves at edge N+1 by 1.
  - Landing: `goomba_y` snaps and `falling` drops at the same edge.
- Simultaneous events:
  - Parked together with any other condition: parked wins, and all registers hold.
  - Landing together with `cand ≥ SCREEN_HEIGHT`: landing wins.
- A `goomba_x` change mid-fall takes effect on the next edge. No state is corrupted.
- Reset asserted mid-fall returns to the reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `game_pkg`:
  - tile codes (`BDR`, `SKY`, `BLK`, `GND`)
  - `BLOCK_WIDTH`, grid dimensions (12 rows, 17 columns)
  - `background_t` typedef
  - the `gravity_state_t` enum (RESET, GROUNDED, FALLING, GONE)
- Sub-module `tile_probe`: combinational. Takes a row, `x_left`, and the background; returns "either of the two columns solid", with column clamping and row ≥ 12 → 0. It is instanced twice, once for support (`rs`) and once for landing (`rl`).

## Test plan
- Reset with row 11 = `GND`, `goomba_x` = 300 → `goomba_y` = 398, `falling` = 0 after the first edge, and it stays 398 for 100 cycles.
- Clear tiles (11,7) and (11,8), `goomba_x` = 300 → `falling` = 1. `goomba_y` steps +1 for 8 cycles, then +2, saturating at +4/cycle. `fell` = 1 once `goomba_y` ≥ 480, and `goomba_y` then holds.
- Start at `goomba_y` = 300 (`START_Y` = 300), row 9 = `BLK` under x = 300 → the Goomba lands with `goomba_y` = 318 exactly and `falling` = 0 on the landing edge.
- Only column 8 is solid below, `goomba_x` = 290 (`colL` = 7, `colR` = 8) → the Goomba stays supported. Move to `goomba_x` = 270 (`colR` = 7) → it falls.
- Mid-fall, set `goomba_x` = 1000 → `goomba_y`, `vel`, and `falling` hold indefinitely.
- Assert `reset` low mid-fall between clock edges → `goomba_y` = 398 and `fell` = 0 immediately.

Source files
------------

// File: rtl/goomba_gravity_mover_pkg.sv
// Shared game definitions: tile codes, grid geometry, background type and
// the vertical-motion state encoding used by the Goomba gravity stage.
package game_pkg;

  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;

  localparam int BLOCK_WIDTH = 40;
  localparam int GRID_ROWS   = 12;
  localparam int GRID_COLS   = 17;

  typedef logic [7:0] tile_t;
  typedef tile_t [GRID_ROWS-1:0][GRID_COLS-1:0] background_t;

  typedef enum logic [1:0] {
    RESET    = 2'd0,
    GROUNDED = 2'd1,
    FALLING  = 2'd2,
    GONE     = 2'd3
  } gravity_state_t;

  // Blocks and ground stop a falling character; sky and border do not.
  function automatic logic is_solid(input tile_t t);
    return (t == BLK) || (t == GND);
  endfunction

endpackage

// File: rtl/goomba_gravity_mover_if.sv
// Signals exchanged between the horizontal Goomba mover / game world and the
// gravity stage: tile grid and X position in, Y position and status out.
interface goomba_gravity_mover_if;
  import game_pkg::*;

  background_t background;
  int          goomba_x;
  int          goomba_y;
  logic        falling;
  logic        fell;

  modport master (
    output background,
    output goomba_x,
    input  goomba_y,
    input  falling,
    input  fell
  );

  modport slave (
    input  background,
    input  goomba_x,
    output goomba_y,
    output falling,
    output fell
  );

endinterface

// File: rtl/goomba_gravity_mover_tile_probe.sv
// Combinational probe: is either tile under the sprite's left or right edge
// solid in the given row? Columns clamp into the grid, rows outside it are air.
module tile_probe
  import game_pkg::*;
#(
  parameter int CHARACTER_WIDTH = 42
) (
  input  int          row,
  input  int          x_left,
  input  background_t background,
  output logic        solid_any
);

  int         col_l_raw;
  int         col_r_raw;
  logic [4:0] col_l;
  logic [4:0] col_r;
  logic [3:0] row_idx;
  logic       row_ok;

  function automatic logic [4:0] clamp_col(input int c);
    if (c < 0)
      return 5'd0;
    else if (c > GRID_COLS - 1)
      return 5'(GRID_COLS - 1);
    else
      return c[4:0];
  endfunction

  // Map the sprite edges to grid columns and test both tiles in the row.
  always_comb begin
    col_l_raw = x_left / BLOCK_WIDTH;
    col_r_raw = (x_left + CHARACTER_WIDTH - 1) / BLOCK_WIDTH;
    col_l     = clamp_col(col_l_raw);
    col_r     = clamp_col(col_r_raw);
    row_ok    = (row >= 0) && (row < GRID_ROWS);
    row_idx   = row_ok ? row[3:0] : 4'd0;
    solid_any = row_ok && (is_solid(background[row_idx][col_l]) ||
                           is_solid(background[row_idx][col_r]));
  end

endmodule

// File: rtl/goomba_gravity_mover.sv
// Vertical motion for the Goomba: gravity with a capped fall speed, landing
// on solid tiles, and detection of falling off the bottom of the screen.
module goomba_gravity_mover
  import game_pkg::*;
#(
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int START_Y         = 398,
  parameter int MAX_FALL_SPEED  = 4,
  parameter int GRAVITY_PERIOD  = 8
) (
  input  logic                   movement_clock,
  input  logic                   reset,
  goomba_gravity_mover_if.slave  bus
);

  localparam int VEL_W  = $clog2(MAX_FALL_SPEED + 1);
  localparam int GCNT_W = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;

  localparam logic [VEL_W-1:0]  VEL_ONE   = VEL_W'(1);
  localparam logic [VEL_W-1:0]  VEL_MAX   = VEL_W'(MAX_FALL_SPEED);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GRAVITY_PERIOD - 1);

  gravity_state_t      state_q, state_d;
  logic signed [31:0]  y_q, y_d;
  logic [VEL_W-1:0]    vel_q, vel_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;

  logic signed [31:0]  cand;
  logic signed [31:0]  row_support;
  logic signed [31:0]  row_land;
  logic signed [31:0]  land_y;
  logic                parked;
  logic                supported;
  logic                landing;

  // Fall speed grows by one pixel/tick per gravity period, up to the cap.
  function automatic logic [VEL_W-1:0] sat_inc_vel(input logic [VEL_W-1:0] v);
    if (v >= VEL_MAX)
      return VEL_MAX;
    else
      return v + VEL_ONE;
  endfunction

  // Rows probed: the one just below the current feet, and the one the feet
  // would reach after this tick's move.
  always_comb begin
    cand        = y_q + signed'(32'(vel_q));
    row_support = (y_q + CHARACTER_WIDTH) / BLOCK_WIDTH;
    row_land    = (cand + CHARACTER_WIDTH) / BLOCK_WIDTH;
    land_y      = row_land * BLOCK_WIDTH - CHARACTER_WIDTH;
    parked      = (bus.goomba_x >= SCREEN_WIDTH);
  end

  tile_probe #(
    .CHARACTER_WIDTH (CHARACTER_WIDTH)
  ) u_support_probe (
    .row        (row_support),
    .x_left     (bus.goomba_x),
    .background (bus.background),
    .solid_any  (supported)
  );

  tile_probe #(
    .CHARACTER_WIDTH (CHARACTER_WIDTH)
  ) u_land_probe (
    .row        (row_land),
    .x_left     (bus.goomba_x),
    .background (bus.background),
    .solid_any  (landing)
  );

  // State, position, speed and gravity counter; reset restores the spawn pose.
  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      state_q <= RESET;
      y_q     <= START_Y;
      vel_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state logic; a parked (killed, off-screen) Goomba freezes everything.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      RESET: begin
        if (supported) begin
          state_d = GROUNDED;
        end else begin
          state_d = FALLING;
          vel_d   = VEL_ONE;
          gcnt_d  = '0;
        end
      end
      GROUNDED: begin
        if (!parked && !supported) begin
          state_d = FALLING;
          vel_d   = VEL_ONE;
          gcnt_d  = '0;
        end
      end
      FALLING: begin
        if (!parked) begin
          // Landing outranks leaving the screen; the snap is always downward
          // because a single move never exceeds one tile.
          if (landing) begin
            y_d     = land_y;
            vel_d   = '0;
            state_d = GROUNDED;
          end else if (cand >= SCREEN_HEIGHT) begin
            y_d     = cand;
            state_d = GONE;
          end else begin
            y_d = cand;
            if (gcnt_q == GCNT_LAST) begin
              gcnt_d = '0;
              vel_d  = sat_inc_vel(vel_q);
            end else begin
              gcnt_d = gcnt_q + GCNT_W'(1);
            end
          end
        end
      end
      default: begin
        // GONE holds until reset.
      end
    endcase
  end

  assign bus.goomba_y = y_q;
  assign bus.falling  = (state_q == FALLING);
  assign bus.fell     = (state_q == GONE);

endmodule

// File: tb/tb_goomba_gravity_mover.sv
// Directed bench for goomba_gravity_mover: resting spawn, gravity ramp to the
// screen bottom, landing snap, two-column support, parking and async reset.
module tb_goomba_gravity_mover;
  import game_pkg::*;

  logic movement_clock = 1'b0;
  logic reset          = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  background_t bg_a;
  background_t bg_b;

  // Expected goomba_y after each move once the parked pause ends (x = 270).
  int exp_y [30] = '{402, 403, 404, 405, 406,
                     408, 410, 412, 414, 416, 418, 420, 422,
                     425, 428, 431, 434, 437, 440, 443, 446,
                     450, 454, 458, 462, 466, 470, 474, 478, 482};

  always #5 movement_clock = ~movement_clock;

  goomba_gravity_mover_if ifa ();
  goomba_gravity_mover_if ifb ();

  goomba_gravity_mover #(.START_Y(398)) dut_a (
    .movement_clock (movement_clock),
    .reset          (reset),
    .bus            (ifa)
  );

  goomba_gravity_mover #(.START_Y(300)) dut_b (
    .movement_clock (movement_clock),
    .reset          (reset),
    .bus            (ifb)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge movement_clock);
    #1;
  endtask

  initial begin
    // Row 11 ground everywhere for A; B additionally has a row-9 block floor.
    for (int r = 0; r < GRID_ROWS; r++)
      for (int c = 0; c < GRID_COLS; c++) begin
        bg_a[r][c] = (r == 11) ? GND : SKY;
        bg_b[r][c] = (r == 11) ? GND : ((r == 9) ? BLK : SKY);
      end
    ifa.background = bg_a;
    ifb.background = bg_b;
    ifa.goomba_x   = 300;
    ifb.goomba_x   = 300;

    #1 reset = 1'b0;
    #1;
    check("reset_y_a",       ifa.goomba_y, 398);
    check("reset_falling_a", ifa.falling,  0);
    check("reset_fell_a",    ifa.fell,     0);
    check("reset_y_b",       ifb.goomba_y, 300);
    #1 reset = 1'b1;

    // A rests on ground; B falls from 300 and lands on the row-9 blocks.
    for (int i = 1; i <= 100; i++) begin
      tick();
      check("rest_y_a",       ifa.goomba_y, 398);
      check("rest_falling_a", ifa.falling,  0);
      if (i == 1) begin
        check("b_fall_start_falling", ifb.falling, 1);
        check("b_fall_start_y",       ifb.goomba_y, 300);
      end
      if (i == 2)  check("b_first_step_y", ifb.goomba_y, 301);
      if (i == 9)  check("b_eighth_step_y", ifb.goomba_y, 308);
      if (i == 10) check("b_speed2_y", ifb.goomba_y, 310);
      if (i == 13) begin
        check("b_preland_y",       ifb.goomba_y, 316);
        check("b_preland_falling", ifb.falling,  1);
      end
      if (i == 14) begin
        check("b_land_y",       ifb.goomba_y, 318);
        check("b_land_falling", ifb.falling,  0);
      end
      if (i == 100) begin
        check("b_rest_y",       ifb.goomba_y, 318);
        check("b_rest_falling", ifb.falling,  0);
      end
    end

    // Only column 8 solid: x=290 spans cols 7/8 (supported), x=270 spans 6/7.
    for (int c = 0; c < GRID_COLS; c++)
      bg_a[11][c] = (c == 8) ? GND : SKY;
    ifa.background = bg_a;
    ifa.goomba_x   = 290;
    tick();
    check("col8_support_falling", ifa.falling,  0);
    check("col8_support_y",       ifa.goomba_y, 398);
    ifa.goomba_x = 270;
    tick();
    check("unsupported_falling", ifa.falling,  1);
    check("unsupported_y",       ifa.goomba_y, 398);
    tick();
    check("fall_step1_y", ifa.goomba_y, 399);
    tick();
    check("fall_step2_y", ifa.goomba_y, 400);
    tick();
    check("fall_step3_y", ifa.goomba_y, 401);

    // Parked mid-fall: everything freezes.
    ifa.goomba_x = 1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("parked_y",       ifa.goomba_y, 401);
      check("parked_falling", ifa.falling,  1);
      check("parked_fell",    ifa.fell,     0);
    end

    // Resume: speed ramp continues from where it froze, then leaves the screen.
    ifa.goomba_x = 270;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("ramp_y",       ifa.goomba_y, exp_y[k]);
      check("ramp_falling", ifa.falling,  (k < 29) ? 1 : 0);
      check("ramp_fell",    ifa.fell,     (k == 29) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gone_y",    ifa.goomba_y, 482);
      check("gone_fell", ifa.fell,     1);
    end

    // Async reset out of GONE clears fell at once.
    for (int c = 0; c < GRID_COLS; c++)
      bg_a[11][c] = GND;
    ifa.background = bg_a;
    ifa.goomba_x   = 300;
    reset = 1'b0;
    #1;
    check("reset_from_gone_fell", ifa.fell,     0);
    check("reset_from_gone_y",    ifa.goomba_y, 398);
    reset = 1'b1;
    tick();
    check("respawn_falling", ifa.falling,  0);
    check("respawn_y",       ifa.goomba_y, 398);

    // Pull tiles (11,7),(11,8) out, fall a little, then reset between edges.
    bg_a[11][7]    = SKY;
    bg_a[11][8]    = SKY;
    ifa.background = bg_a;
    tick();
    check("drop_falling", ifa.falling,  1);
    check("drop_y",       ifa.goomba_y, 398);
    tick();
    check("drop_step1_y", ifa.goomba_y, 399);
    tick();
    check("drop_step2_y", ifa.goomba_y, 400);
    #2 reset = 1'b0;
    #1;
    check("midfall_reset_y",       ifa.goomba_y, 398);
    check("midfall_reset_fell",    ifa.fell,     0);
    check("midfall_reset_falling", ifa.falling,  0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
